// File: rtl/adc_emulator.sv
// adc_emulator
// Stands in for a 16-bit serial ADC (CNV / SCK / SDO, MSB first) in the
// 210 MHz acquisition domain. It watches the master's convert strobe and
// serial clock, then shifts out a word taken from a selectable source.
//
// State table
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | waiting for a CNV rise; any SCK edge here is a stray edge
//   ST_CONVERT | CNV high, measuring its width; the word is already latched
//   ST_SHIFT   | presenting shift_q[15] on SDO, advancing on each SCK rise
//
// Ports
//   clk210_p        in   210 MHz clock
//   reset_n_p       in   asynchronous active-low reset
//   cnv_p           in   convert strobe from the master
//   sck_p           in   serial clock from the master (idles high)
//   sdo_p           out  serial data, MSB first, straight from a register
//   emu_mode_p      in   source: 0 sample_data_p, 1 ramp, 2 LFSR, 3 fixed
//   sample_data_p   in   external word used in mode 0
//   clear_errors_p  in   synchronous clear of error_flags_p
//   frame_done_p    out  one-cycle pulse after the 16th bit is consumed
//   conv_count_p    out  completed-frame count, wraps at 2^16
//   error_flags_p   out  sticky: [0] CNV too short, [1] stray SCK, [2] short frame
//   busy_p          out  state is not ST_IDLE
module adc_emulator #(
   parameter int unsigned CNV_MIN_HIGH_param  = 6,
   parameter logic [15:0] RAMP_STEP_param     = 16'd1,
   parameter logic [15:0] LFSR_SEED_param     = 16'hACE1,
   parameter logic [15:0] FIXED_PATTERN_param = 16'hA5C3
) (
   input  logic        clk210_p,
   input  logic        reset_n_p,
   input  logic        cnv_p,
   input  logic        sck_p,
   output logic        sdo_p,
   input  logic [1:0]  emu_mode_p,
   input  logic [15:0] sample_data_p,
   input  logic        clear_errors_p,
   output logic        frame_done_p,
   output logic [15:0] conv_count_p,
   output logic [2:0]  error_flags_p,
   output logic        busy_p
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_SHIFT   = 2'd2
   } state_t;

   state_t      state_q, state_nxt;
   logic        cnv_q, sck_q;
   logic [15:0] data_q, data_nxt;
   logic [15:0] shift_q, shift_nxt;
   logic [7:0]  hi_cnt_q, hi_cnt_nxt;
   logic [3:0]  bit_cnt_q, bit_cnt_nxt;
   logic [15:0] ramp_q, lfsr_q, conv_count_q;
   logic [2:0]  err_q, err_set;
   logic        frame_done_q, frame_done_nxt;
   logic        advance;

   logic        cnv_rise, cnv_fall, sck_rise, sck_fall, sck_edge;
   logic [15:0] ramp_adv, lfsr_adv;
   logic [8:0]  hi_cnt_inc;
   logic        hi_ok;
   logic        last_bit;

   assign cnv_rise = cnv_p & ~cnv_q;
   assign cnv_fall = ~cnv_p & cnv_q;
   assign sck_rise = sck_p & ~sck_q;
   assign sck_fall = ~sck_p & sck_q;
   assign sck_edge = sck_rise | sck_fall;

   assign ramp_adv = ramp_q + RAMP_STEP_param;
   assign lfsr_adv = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

   // The cycle that sees the fall still counts as high time, hence the +1.
   assign hi_cnt_inc = {1'b0, hi_cnt_q} + 9'd1;
   assign hi_ok      = ({23'd0, hi_cnt_inc} >= CNV_MIN_HIGH_param);
   assign last_bit   = sck_rise && (bit_cnt_q == 4'd15);

   function automatic logic [15:0] src_word(input logic [1:0]  mode,
                                            input logic [15:0] sample,
                                            input logic [15:0] ramp,
                                            input logic [15:0] lfsr);
      case (mode)
         2'd0:    src_word = sample;
         2'd1:    src_word = ramp;
         2'd2:    src_word = lfsr;
         default: src_word = FIXED_PATTERN_param;
      endcase
   endfunction

   always_comb begin
      state_nxt      = state_q;
      data_nxt       = data_q;
      shift_nxt      = shift_q;
      hi_cnt_nxt     = hi_cnt_q;
      bit_cnt_nxt    = bit_cnt_q;
      err_set        = 3'b000;
      frame_done_nxt = 1'b0;
      advance        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (sck_edge) err_set[1] = 1'b1;
            if (cnv_rise) begin
               data_nxt   = src_word(emu_mode_p, sample_data_p, ramp_q, lfsr_q);
               hi_cnt_nxt = 8'd0;
               state_nxt  = ST_CONVERT;
            end
         end

         ST_CONVERT: begin
            if (sck_edge) err_set[1] = 1'b1;
            if (cnv_fall) begin
               if (hi_ok) begin
                  shift_nxt   = data_q;
                  bit_cnt_nxt = 4'd0;
                  state_nxt   = ST_SHIFT;
               end else begin
                  err_set[0] = 1'b1;
                  shift_nxt  = 16'd0;
                  state_nxt  = ST_IDLE;
               end
            end else if (cnv_p && (hi_cnt_q != 8'hFF)) begin
               hi_cnt_nxt = hi_cnt_q + 8'd1;
            end
         end

         ST_SHIFT: begin
            if (sck_rise) begin
               shift_nxt   = {shift_q[14:0], 1'b0};
               bit_cnt_nxt = bit_cnt_q + 4'd1;
               if (last_bit) begin
                  frame_done_nxt = 1'b1;
                  advance        = 1'b1;
                  state_nxt      = ST_IDLE;
               end
            end
            // A new CNV rise is always honoured. If it coincides with the
            // final SCK rise the frame still completes and the new word is
            // taken from the already-advanced generators.
            if (cnv_rise) begin
               if (last_bit) begin
                  data_nxt = src_word(emu_mode_p, sample_data_p, ramp_adv, lfsr_adv);
               end else begin
                  err_set[2] = 1'b1;
                  data_nxt   = src_word(emu_mode_p, sample_data_p, ramp_q, lfsr_q);
               end
               shift_nxt  = 16'd0;
               hi_cnt_nxt = 8'd0;
               state_nxt  = ST_CONVERT;
            end
         end

         default: begin
            shift_nxt = 16'd0;
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk210_p or negedge reset_n_p) begin
      if (!reset_n_p) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   always_ff @(posedge clk210_p or negedge reset_n_p) begin
      if (!reset_n_p) begin
         cnv_q        <= 1'b0;
         sck_q        <= 1'b1;
         data_q       <= 16'd0;
         shift_q      <= 16'd0;
         hi_cnt_q     <= 8'd0;
         bit_cnt_q    <= 4'd0;
         ramp_q       <= 16'd0;
         lfsr_q       <= LFSR_SEED_param;
         conv_count_q <= 16'd0;
         err_q        <= 3'b000;
         frame_done_q <= 1'b0;
      end else begin
         cnv_q        <= cnv_p;
         sck_q        <= sck_p;
         data_q       <= data_nxt;
         shift_q      <= shift_nxt;
         hi_cnt_q     <= hi_cnt_nxt;
         bit_cnt_q    <= bit_cnt_nxt;
         frame_done_q <= frame_done_nxt;
         // A fresh error in the clearing cycle survives the clear.
         err_q        <= (clear_errors_p ? 3'b000 : err_q) | err_set;
         if (advance) begin
            conv_count_q <= conv_count_q + 16'd1;
            ramp_q       <= ramp_adv;
            lfsr_q       <= lfsr_adv;
         end
      end
   end

   // shift_q is zero outside a live frame, so SDO rests low.
   assign sdo_p         = shift_q[15];
   assign frame_done_p  = frame_done_q;
   assign conv_count_p  = conv_count_q;
   assign error_flags_p = err_q;
   assign busy_p        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adc_emulator.sv
`timescale 1ns/1ps
module tb_adc_emulator;

   localparam logic [15:0] STEP  = 16'h8000;
   localparam logic [15:0] SEED  = 16'hACE1;
   localparam logic [15:0] FIXED = 16'hA5C3;

   logic        clk210_p = 1'b0;
   logic        reset_n_p = 1'b0;
   logic        cnv_p = 1'b0;
   logic        sck_p = 1'b1;
   logic        sdo_p;
   logic [1:0]  emu_mode_p = 2'd0;
   logic [15:0] sample_data_p = 16'd0;
   logic        clear_errors_p = 1'b0;
   logic        frame_done_p;
   logic [15:0] conv_count_p;
   logic [2:0]  error_flags_p;
   logic        busy_p;

   adc_emulator #(
      .CNV_MIN_HIGH_param (6),
      .RAMP_STEP_param    (STEP),
      .LFSR_SEED_param    (SEED),
      .FIXED_PATTERN_param(FIXED)
   ) dut (
      .clk210_p      (clk210_p),
      .reset_n_p     (reset_n_p),
      .cnv_p         (cnv_p),
      .sck_p         (sck_p),
      .sdo_p         (sdo_p),
      .emu_mode_p    (emu_mode_p),
      .sample_data_p (sample_data_p),
      .clear_errors_p(clear_errors_p),
      .frame_done_p  (frame_done_p),
      .conv_count_p  (conv_count_p),
      .error_flags_p (error_flags_p),
      .busy_p        (busy_p)
   );

   always #5 clk210_p = ~clk210_p;

   int n_pass = 0;
   int n_total = 0;
   int done_cnt = 0;

   always @(negedge clk210_p) if (frame_done_p === 1'b1) done_cnt++;

   // reference model state
   logic [15:0] ramp_m, lfsr_m, count_m;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      logic fb;
      fb = v[15] ^ v[13] ^ v[12] ^ v[10];
      return {v[14:0], fb};
   endfunction

   function automatic logic [15:0] model_word(input logic [1:0] m, input logic [15:0] s);
      case (m)
         2'd0: return s;
         2'd1: return ramp_m;
         2'd2: return lfsr_m;
         default: return FIXED;
      endcase
   endfunction

   task automatic model_complete();
      count_m = count_m + 16'd1;
      ramp_m  = ramp_m + STEP;
      lfsr_m  = lfsr_step(lfsr_m);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic do_reset();
      reset_n_p = 1'b0;
      cnv_p = 1'b0;
      sck_p = 1'b1;
      clear_errors_p = 1'b0;
      repeat (2) @(posedge clk210_p);
      @(negedge clk210_p) reset_n_p = 1'b1;
      @(posedge clk210_p);
      #1;
      ramp_m = 16'd0;
      lfsr_m = SEED;
      count_m = 16'd0;
   endtask

   task automatic clear_errs();
      @(posedge clk210_p); #1 clear_errors_p = 1'b1;
      @(posedge clk210_p); #1 clear_errors_p = 1'b0;
   endtask

   task automatic stray_sck();
      @(posedge clk210_p); #1 sck_p = 1'b0;
      @(posedge clk210_p); #1 sck_p = 1'b1;
      repeat (2) @(posedge clk210_p);
      #1;
   endtask

   // Master side: CNV high for hi cycles, then nbits SCK pulses; SDO sampled
   // on the last low-phase negedge before each rise.
   task automatic run_frame(input logic [1:0] m, input logic [15:0] s,
                            input int hi, input int lo, input int hh, input int nbits,
                            output logic [15:0] w);
      w = 16'd0;
      @(posedge clk210_p); #1;
      emu_mode_p = m;
      sample_data_p = s;
      cnv_p = 1'b1;
      repeat (hi) @(posedge clk210_p);
      #1 cnv_p = 1'b0;
      repeat (2) @(posedge clk210_p);
      for (int b = 0; b < nbits; b++) begin
         #1 sck_p = 1'b0;
         repeat (lo - 1) @(posedge clk210_p);
         @(negedge clk210_p) w = {w[14:0], sdo_p};
         @(posedge clk210_p); #1 sck_p = 1'b1;
         repeat (hh) @(posedge clk210_p);
      end
      repeat (3) @(posedge clk210_p);
      #1;
   endtask

   typedef struct {
      bit          rst;
      logic [1:0]  mode;
      logic [15:0] sample;
      int          hi, lo, hh;
      logic [15:0] exp_word;
      logic [15:0] exp_count;
   } vec_t;

   vec_t vecs[8];

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] w, e;
      int d0, r, hi;
      logic [1:0] m;
      logic [15:0] s;

      vecs[0] = '{1'b1, 2'd3, 16'h0000,   6, 1, 1, 16'hA5C3, 16'd1};
      vecs[1] = '{1'b1, 2'd1, 16'h0000,   6, 1, 1, 16'h0000, 16'd1};
      vecs[2] = '{1'b0, 2'd1, 16'h0000,   6, 1, 1, 16'h8000, 16'd2};
      vecs[3] = '{1'b0, 2'd1, 16'h0000,   6, 1, 1, 16'h0000, 16'd3};
      vecs[4] = '{1'b1, 2'd2, 16'h0000,   6, 1, 1, 16'hACE1, 16'd1};
      vecs[5] = '{1'b0, 2'd2, 16'h0000,   6, 1, 1, 16'h59C3, 16'd2};
      vecs[6] = '{1'b0, 2'd0, 16'hBEEF,   7, 2, 3, 16'hBEEF, 16'd3};
      vecs[7] = '{1'b0, 2'd3, 16'h0000, 300, 1, 2, 16'hA5C3, 16'd4};

      do_reset();
      check("reset sdo", 32'(sdo_p), 32'd0);
      check("reset frame_done", 32'(frame_done_p), 32'd0);
      check("reset count", 32'(conv_count_p), 32'd0);
      check("reset errors", 32'(error_flags_p), 32'd0);
      check("reset busy", 32'(busy_p), 32'd0);

      // directed table
      for (int i = 0; i < 8; i++) begin
         if (vecs[i].rst) do_reset();
         d0 = done_cnt;
         run_frame(vecs[i].mode, vecs[i].sample, vecs[i].hi, vecs[i].lo, vecs[i].hh, 16, w);
         check($sformatf("vec%0d word", i), 32'(w), 32'(vecs[i].exp_word));
         check($sformatf("vec%0d count", i), 32'(conv_count_p), 32'(vecs[i].exp_count));
         check($sformatf("vec%0d done pulses", i), 32'(done_cnt - d0), 32'd1);
         check($sformatf("vec%0d errors", i), 32'(error_flags_p), 32'd0);
      end

      // slow master, sample word changes mid-frame
      do_reset();
      fork
         run_frame(2'd0, 16'h1234, 33, 33, 33, 16, w);
         begin
            repeat (200) @(posedge clk210_p);
            #1 sample_data_p = 16'hFFFF;
         end
      join
      check("slow word", 32'(w), 32'h1234);
      check("slow count", 32'(conv_count_p), 32'd1);

      // short CNV, stray SCK, clear, clear colliding with a new error
      do_reset();
      d0 = done_cnt;
      run_frame(2'd3, 16'h0, 3, 1, 1, 0, w);
      check("short cnv err", 32'(error_flags_p), 32'b001);
      check("short cnv no done", 32'(done_cnt - d0), 32'd0);
      check("short cnv idle", 32'(busy_p), 32'd0);
      run_frame(2'd3, 16'h0, 5, 1, 1, 0, w);
      check("cnv 5 count", 32'(conv_count_p), 32'd0);
      stray_sck();
      check("stray sck err", 32'(error_flags_p), 32'b011);
      clear_errs();
      check("clear err", 32'(error_flags_p), 32'b000);
      @(posedge clk210_p); #1 sck_p = 1'b0; clear_errors_p = 1'b1;
      @(posedge clk210_p); #1 clear_errors_p = 1'b0; sck_p = 1'b1;
      check("clear vs new error", 32'(error_flags_p), 32'b010);
      clear_errs();

      // aborted frame followed by a full one
      do_reset();
      run_frame(2'd1, 16'h0, 6, 1, 1, 8, w);
      check("partial busy", 32'(busy_p), 32'd1);
      run_frame(2'd1, 16'h0, 6, 1, 1, 16, w);
      check("after abort word", 32'(w), 32'h0000);
      check("after abort err", 32'(error_flags_p), 32'b100);
      check("after abort count", 32'(conv_count_p), 32'd1);
      run_frame(2'd1, 16'h0, 6, 2, 1, 16, w);
      check("after abort next word", 32'(w), 32'h8000);

      // asynchronous reset mid-shift
      do_reset();
      run_frame(2'd3, 16'h0, 6, 1, 1, 2, w);
      check("pre-reset sdo", 32'(sdo_p), 32'd1);
      check("pre-reset busy", 32'(busy_p), 32'd1);
      #1 reset_n_p = 1'b0;
      #1;
      check("async reset sdo", 32'(sdo_p), 32'd0);
      check("async reset busy", 32'(busy_p), 32'd0);
      do_reset();

      // randomized frames against the model
      for (int k = 0; k < 24; k++) begin
         r = $urandom_range(0, 7);
         d0 = done_cnt;
         if (r == 0) begin
            hi = $urandom_range(1, 5);
            run_frame(2'd3, 16'h0, hi, 1, 1, 0, w);
            check("rand short err", 32'(error_flags_p), 32'b001);
            check("rand short count", 32'(conv_count_p), 32'(count_m));
            clear_errs();
            check("rand clear", 32'(error_flags_p), 32'b000);
         end else begin
            m = 2'($urandom_range(0, 3));
            s = 16'($urandom);
            e = model_word(m, s);
            run_frame(m, s, $urandom_range(6, 12), $urandom_range(1, 4),
                      $urandom_range(1, 4), 16, w);
            model_complete();
            check($sformatf("rand%0d word mode%0d", k, m), 32'(w), 32'(e));
            check($sformatf("rand%0d count", k), 32'(conv_count_p), 32'(count_m));
            check($sformatf("rand%0d done", k), 32'(done_cnt - d0), 32'd1);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
